seq_shifter: RTL and testbench

- Parametrised, multi-cycle successor to the datapath's single-bit shifter.
- Shifts a WIDTH-bit operand by a run-time amount, STEP bit positions per clock.
- Supports pass, logical left, logical right and arithmetic right, plus optional rotate-right.
- Sits between the register file read port and the ALU B input; valid/ready handshakes let the controller stall while a multi-bit shift completes.

---
 rtl/seq_shifter.sv | 138 +++++++++++++
 tb/tb_seq_shifter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: STEP bit positions per clock, valid/ready on both sides.
// Optional rotate-right (in_op=100) is built only when SEQ_SHIFTER_ROR_EN is defined.
module seq_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam logic [2:0] OpLsl = 3'b001;
  localparam logic [2:0] OpLsr = 3'b010;
  localparam logic [2:0] OpAsr = 3'b011;
`ifdef SEQ_SHIFTER_ROR_EN
  localparam logic [2:0] OpRor = 3'b100;
`endif

  localparam logic [AMT_W-1:0] StepV = AMT_W'(STEP);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] rem_q;
  logic [2:0]       op_q;
  logic             carry_q;

  logic             op_shifts;
  logic [AMT_W-1:0] step_k;
  logic [WIDTH-1:0] shift_data;
  logic             shift_carry;

  always_comb begin
    op_shifts = (in_op == OpLsl) || (in_op == OpLsr) || (in_op == OpAsr);
`ifdef SEQ_SHIFTER_ROR_EN
    op_shifts = op_shifts || (in_op == OpRor);
`endif
  end

  // A final partial step shifts only the remaining positions.
  assign step_k = (rem_q < StepV) ? rem_q : StepV;

  always_comb begin
    shift_data  = data_q;
    shift_carry = carry_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (AMT_W'(i) < rem_q) begin
        case (op_q)
          OpLsl: begin
            shift_carry = shift_data[WIDTH-1];
            shift_data  = {shift_data[WIDTH-2:0], 1'b0};
          end
          OpLsr: begin
            shift_carry = shift_data[0];
            shift_data  = {1'b0, shift_data[WIDTH-1:1]};
          end
          OpAsr: begin
            // The sign bit never changes under ASR, so it is the original MSB.
            shift_carry = shift_data[0];
            shift_data  = {shift_data[WIDTH-1], shift_data[WIDTH-1:1]};
          end
`ifdef SEQ_SHIFTER_ROR_EN
          OpRor: begin
            shift_carry = shift_data[0];
            shift_data  = {shift_data[0], shift_data[WIDTH-1:1]};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      data_q    <= '0;
      rem_q     <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            data_q   <= in_data;
            op_q     <= in_op;
            rem_q    <= in_amt;
            carry_q  <= 1'b0;
            in_ready <= 1'b0;
            if (in_amt == '0 || !op_shifts) begin
              state     <= StDone;
              out_valid <= 1'b1;
            end else begin
              state <= StShift;
            end
          end
        end
        StShift: begin
          data_q  <= shift_data;
          carry_q <= shift_carry;
          rem_q   <= rem_q - step_k;
          if (rem_q == step_k) begin
            state     <= StDone;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: one STEP=1 and one STEP=4 instance, scoreboard of expected results.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v1 = 1'b0, v4 = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_amt = '0;
  logic [2:0]  in_op = '0;
  logic        ir1, ir4, ov1, ov4, oc1, oc4;
  logic [15:0] od1, od4;
  logic        sel = 1'b0;
  logic        ir, ov, oc;
  logic [15:0] od;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .STEP(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(ir1), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_carry(oc1)
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(v4), .in_ready(ir4), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_carry(oc4)
  );

  assign ir = sel ? ir4 : ir1;
  assign ov = sel ? ov4 : ov1;
  assign od = sel ? od4 : od1;
  assign oc = sel ? oc4 : oc1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit supported(input logic [2:0] op);
`ifdef SEQ_SHIFTER_ROR_EN
    return op inside {3'b001, 3'b010, 3'b011, 3'b100};
`else
    return op inside {3'b001, 3'b010, 3'b011};
`endif
  endfunction

  // Reference: amt single-bit shifts, independent of STEP.
  function automatic logic [16:0] model(input logic [15:0] d, input int amt, input logic [2:0] op);
    logic [15:0] r = d;
    logic        c = 1'b0;
    if (!supported(op)) return {1'b0, d};
    for (int i = 0; i < amt; i++) begin
      case (op)
        3'b001:  begin c = r[15]; r = {r[14:0], 1'b0}; end
        3'b010:  begin c = r[0];  r = {1'b0, r[15:1]}; end
        3'b011:  begin c = r[0];  r = {d[15], r[15:1]}; end
        default: begin c = r[0];  r = {r[0], r[15:1]}; end
      endcase
    end
    return {c, r};
  endfunction

  function automatic int exp_lat(input int amt, input logic [2:0] op, input int step);
    if (amt == 0 || !supported(op)) return 0;
    return (amt + step - 1) / step;
  endfunction

  task automatic drive(input bit s4, input logic [15:0] d, input int amt, input logic [2:0] op,
                       input bit push);
    int n = 0;
    logic [16:0] m;
    exp_t e;
    sel = s4;
    while (ir !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("ready_wait", {31'd0, ir}, 32'd1);
    in_data = d;
    in_amt  = amt[3:0];
    in_op   = op;
    if (s4) v4 = 1'b1; else v1 = 1'b1;
    if (push) begin
      m = model(d, amt, op);
      e.data = m[15:0]; e.carry = m[16]; e.lat = exp_lat(amt, op, s4 ? 4 : 1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    v1 = 1'b0; v4 = 1'b0;
  endtask

  task automatic collect(output exp_t e);
    int n = 0;
    while (ov !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      e.data = '0; e.carry = 1'b0; e.lat = 0;
    end else begin
      e = sb.pop_front();
      check("latency", n, e.lat);
      check("out_data", {16'd0, od}, {16'd0, e.data});
      check("out_carry", {31'd0, oc}, {31'd0, e.carry});
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_take", {31'd0, ir}, 32'd1);
    check("valid_after_take", {31'd0, ov}, 32'd0);
  endtask

  task automatic send(input bit s4, input logic [15:0] d, input int amt, input logic [2:0] op);
    exp_t e;
    drive(s4, d, amt, op, 1'b1);
    collect(e);
    release_out();
  endtask

  initial begin
    exp_t held;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, ir1}, 32'd1);
    check("rst_out_valid", {31'd0, ov1}, 32'd0);
    check("rst_out_data", {16'd0, od1}, 32'd0);
    check("rst_out_carry", {31'd0, oc1}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // STEP=1
    send(1'b0, 16'h8001, 1, 3'b001);
    send(1'b0, 16'h8000, 15, 3'b011);
    send(1'b0, 16'h8000, 15, 3'b010);
    send(1'b0, 16'hA5C3, 7, 3'b001);
    send(1'b0, 16'h0001, 1, 3'b100);
    send(1'b0, 16'h1234, 5, 3'b111);

    // STEP=4
    send(1'b1, 16'hF0F0, 6, 3'b010);
    send(1'b1, 16'hF0F0, 0, 3'b010);
    send(1'b1, 16'h1234, 9, 3'b001);
    send(1'b1, 16'h8F00, 7, 3'b011);
    send(1'b1, 16'h8001, 15, 3'b100);
    send(1'b1, 16'h4321, 4, 3'b010);

    // Backpressure with a queued request held on in_valid
    drive(1'b0, 16'h00F1, 3, 3'b010, 1'b1);
    collect(held);
    in_data = 16'hC003; in_amt = 4'd2; in_op = 3'b001; v1 = 1'b1;
    sb.push_back('{data: 16'h000C, carry: 1'b1, lat: 2});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_data", {16'd0, od1}, {16'd0, held.data});
      check("bp_carry", {31'd0, oc1}, {31'd0, held.carry});
      check("bp_in_ready", {31'd0, ir1}, 32'd0);
      check("bp_valid", {31'd0, ov1}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_ready_back", {31'd0, ir1}, 32'd1);
    @(posedge clk); #1;
    v1 = 1'b0;
    check("bp_queued_accepted", {31'd0, ir1}, 32'd0);
    collect(held);
    release_out();

    // Reset in the third cycle of an amt-10 LSL; no result may appear
    drive(1'b0, 16'h0F0F, 10, 3'b001, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, ov1}, 32'd0);
    check("mid_rst_data", {16'd0, od1}, 32'd0);
    check("mid_rst_carry", {31'd0, oc1}, 32'd0);
    check("mid_rst_ready", {31'd0, ir1}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, ir1}, 32'd1);
    send(1'b0, 16'h0F0F, 10, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
